// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// stage indices and default parameter values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StPend  = 2'd2
    } pipe_state_e;

    localparam int unsigned STG_IF = 0;
    localparam int unsigned STG_ID = 1;
    localparam int unsigned STG_EX = 2;

    localparam int unsigned DEF_NUM_STAGES   = 3;
    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_JUMP_STAGE   = STG_EX;
    localparam int unsigned DEF_FLUSH_CYCLES = 2;
    localparam int unsigned DEF_HOLD_TIMEOUT = 255;

endpackage

// File: rtl/hold_timer.sv
// Counts consecutive cycles with any stall request and pulses once when the
// count reaches HOLD_TIMEOUT; re-arms only after a hold-free cycle.
module hold_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic any_hold,
    output logic timeout
);

    localparam int unsigned CntW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(HOLD_TIMEOUT);
    localparam logic [CntW-1:0] CntFire = CntW'(HOLD_TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!any_hold) begin
            cnt_q <= '0;
        end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Counter saturates at CntMax, so the fire value is only seen once per hold.
    assign timeout = !rst && any_hold && (cnt_q == CntFire);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: decodes per-stage hold requests and
// sequences jump redirects (immediate, pending behind older holds, flushing).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned JUMP_STAGE   = DEF_JUMP_STAGE,
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     jump_addr_i,
    input  logic                  jump_en_i,
    input  logic [NUM_STAGES-1:0] hold_req_i,
    output logic [ADDR_W-1:0]     jump_addr_o,
    output logic                  jump_en_o,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  hold_o,
    output logic                  jump_overrun_o,
    output logic                  hold_timeout_o
);

    localparam int unsigned FcW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FcW-1:0] FcReload = FcW'(FLUSH_CYCLES - 1);
    localparam logic [FcW-1:0] FcLast   = FcW'(1);

    pipe_state_e             state_q;
    logic [ADDR_W-1:0]       pend_addr_q;
    logic [FcW-1:0]          flush_cnt_q;

    logic                    any_hold;
    logic                    hold_above;
    logic                    above;
    logic                    accept;
    logic                    fire;
    logic [NUM_STAGES-1:0]   base_stall;
    logic [NUM_STAGES-1:0]   base_flush;
    logic [NUM_STAGES-1:0]   front_mask;
    logic [NUM_STAGES-1:0]   jump_mask;

    // Stall everything at or below the oldest requester, bubble the stage after it.
    always_comb begin
        any_hold   = |hold_req_i;
        hold_above = 1'b0;
        above      = 1'b0;
        base_stall = '0;
        base_flush = '0;
        front_mask = '0;
        jump_mask  = '0;
        for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
            above         = above | hold_req_i[s];
            base_stall[s] = above;
            if (s > int'(JUMP_STAGE) && hold_req_i[s]) begin
                hold_above = 1'b1;
            end
        end
        for (int s = STG_IF; s < int'(NUM_STAGES); s++) begin
            front_mask[s] = (s < int'(JUMP_STAGE));
            jump_mask[s]  = (s <= int'(JUMP_STAGE));
        end
        for (int s = 1; s < int'(NUM_STAGES); s++) begin
            base_flush[s] = base_stall[s-1] & ~base_stall[s];
        end
    end

    assign accept = (state_q != StPend) && jump_en_i && !hold_above;
    assign fire   = accept || ((state_q == StPend) && !hold_above);

    always_comb begin
        jump_en_o      = fire && !rst;
        jump_overrun_o = !rst && (state_q == StPend) && jump_en_i;
        jump_addr_o    = jump_addr_i;
        stall_o        = base_stall;
        flush_o        = base_flush;
        if (rst) begin
            jump_addr_o = '0;
        end else if (fire) begin
            if (state_q == StPend) begin
                jump_addr_o = pend_addr_q;
            end
            flush_o = flush_o | front_mask;
            stall_o = stall_o & ~jump_mask;
        end else if (state_q == StFlush) begin
            flush_o = flush_o | front_mask;
            stall_o = stall_o & ~front_mask;
        end else if (state_q == StPend) begin
            stall_o = stall_o | jump_mask;
        end
        hold_o = (|stall_o) || (|(flush_o & front_mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pend_addr_q <= '0;
            flush_cnt_q <= '0;
        end else if (fire) begin
            if (FLUSH_CYCLES > 1) begin
                state_q     <= StFlush;
                flush_cnt_q <= FcReload;
            end else begin
                state_q     <= StRun;
                flush_cnt_q <= '0;
            end
        end else begin
            unique case (state_q)
                StRun, StFlush: begin
                    if (jump_en_i) begin
                        // Blocked by an older stage: park the target until it drains.
                        state_q     <= StPend;
                        pend_addr_q <= jump_addr_i;
                        flush_cnt_q <= '0;
                    end else if (state_q == StFlush) begin
                        if (flush_cnt_q <= FcLast) begin
                            state_q     <= StRun;
                            flush_cnt_q <= '0;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - 1'b1;
                        end
                    end
                end
                StPend: begin
                    state_q <= StPend;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    hold_timer #(
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .any_hold(any_hold),
        .timeout (hold_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a default 3-stage instance and a 4-stage instance with a
// short hold timeout, driven cycle by cycle against a queue of expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        je_a = 1'b0;
    logic        je_b = 1'b0;
    logic [2:0]  hr_a = '0;
    logic [3:0]  hr_b = '0;

    logic [31:0] a_addr, b_addr;
    logic        a_jen, b_jen;
    logic [2:0]  a_stall, a_flush;
    logic [3:0]  b_stall, b_flush;
    logic        a_hold, b_hold, a_ovr, b_ovr, a_tmo, b_tmo;

    always #5 clk = ~clk;

    pipe_ctrl u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .jump_addr_i   (addr),
        .jump_en_i     (je_a),
        .hold_req_i    (hr_a),
        .jump_addr_o   (a_addr),
        .jump_en_o     (a_jen),
        .stall_o       (a_stall),
        .flush_o       (a_flush),
        .hold_o        (a_hold),
        .jump_overrun_o(a_ovr),
        .hold_timeout_o(a_tmo)
    );

    pipe_ctrl #(
        .NUM_STAGES  (4),
        .ADDR_W      (32),
        .JUMP_STAGE  (2),
        .FLUSH_CYCLES(2),
        .HOLD_TIMEOUT(4)
    ) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .jump_addr_i   (addr),
        .jump_en_i     (je_b),
        .hold_req_i    (hr_b),
        .jump_addr_o   (b_addr),
        .jump_en_o     (b_jen),
        .stall_o       (b_stall),
        .flush_o       (b_flush),
        .hold_o        (b_hold),
        .jump_overrun_o(b_ovr),
        .hold_timeout_o(b_tmo)
    );

    typedef struct {
        bit          dut;
        logic        jen;
        logic [31:0] addr;
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic        hold;
        logic        ovr;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the selected instance (d=1 -> 4-stage) and queue its expectation.
    task automatic cyc(input string tag, input bit d, input logic r, input logic je,
                       input logic [31:0] a, input logic [3:0] hr,
                       input logic e_jen, input logic [31:0] e_addr,
                       input logic [3:0] e_st, input logic [3:0] e_fl,
                       input logic e_hold, input logic e_ovr, input logic e_tmo);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst  = r;
        addr = a;
        je_a = d ? 1'b0 : je;
        je_b = d ? je : 1'b0;
        hr_a = d ? 3'b000 : hr[2:0];
        hr_b = d ? hr : 4'b0000;
        e.dut = d; e.jen = e_jen; e.addr = e_addr; e.stall = e_st; e.flush = e_fl;
        e.hold = e_hold; e.ovr = e_ovr; e.tmo = e_tmo;
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        if (o.dut) begin
            check({tag, ".jen"},   b_jen,   o.jen);
            check({tag, ".addr"},  b_addr,  o.addr);
            check({tag, ".stall"}, b_stall, o.stall);
            check({tag, ".flush"}, b_flush, o.flush);
            check({tag, ".hold"},  b_hold,  o.hold);
            check({tag, ".ovr"},   b_ovr,   o.ovr);
            check({tag, ".tmo"},   b_tmo,   o.tmo);
        end else begin
            check({tag, ".jen"},   a_jen,   o.jen);
            check({tag, ".addr"},  a_addr,  o.addr);
            check({tag, ".stall"}, {1'b0, a_stall}, o.stall);
            check({tag, ".flush"}, {1'b0, a_flush}, o.flush);
            check({tag, ".hold"},  a_hold,  o.hold);
            check({tag, ".ovr"},   a_ovr,   o.ovr);
            check({tag, ".tmo"},   a_tmo,   o.tmo);
        end
    endtask

    initial begin
        // Reset behaviour on the default instance
        cyc("rst_hold", 0, 1, 1, 32'h100, 4'b0010, 0, 0, 4'b0011, 4'b0100, 1, 0, 0);
        cyc("rst_idle", 0, 1, 0, 32'h0,   4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        cyc("idle",     0, 0, 0, 32'h44,  4'b0000, 0, 32'h44, 4'b0000, 4'b0000, 0, 0, 0);

        // Plain jump: accept, one more flush cycle, back to run
        cyc("jmp",      0, 0, 1, 32'h100, 4'b0000, 1, 32'h100, 4'b0000, 4'b0011, 1, 0, 0);
        cyc("jmp_fl",   0, 0, 0, 32'h55,  4'b0000, 0, 32'h55,  4'b0000, 4'b0011, 1, 0, 0);
        cyc("jmp_run",  0, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            cyc("hold_id", 0, 0, 0, 32'h0, 4'b0010, 0, 0, 4'b0011, 4'b0100, 1, 0, 0);
        end
        cyc("hold_rel", 0, 0, 0, 32'h0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

        // Hold at the jump stage is overridden
        cyc("ovr_hold", 0, 0, 1, 32'h140, 4'b0100, 1, 32'h140, 4'b0000, 4'b0011, 1, 0, 0);
        cyc("ovr_fl",   0, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0011, 1, 0, 0);
        cyc("ovr_run",  0, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);

        // Jump during flush restarts the flush count
        cyc("rs_jmp1",  0, 0, 1, 32'h100, 4'b0000, 1, 32'h100, 4'b0000, 4'b0011, 1, 0, 0);
        cyc("rs_jmp2",  0, 0, 1, 32'h180, 4'b0000, 1, 32'h180, 4'b0000, 4'b0011, 1, 0, 0);
        cyc("rs_fl",    0, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0011, 1, 0, 0);
        cyc("rs_run",   0, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);

        // 4-stage instance: pending jump behind an older hold, overrun, release
        cyc("b_idle",   1, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);
        cyc("pend_in",  1, 0, 1, 32'h200, 4'b1000, 0, 32'h200, 4'b1111, 4'b0000, 1, 0, 0);
        cyc("pend",     1, 0, 0, 32'h0,   4'b1000, 0, 0,       4'b1111, 4'b0000, 1, 0, 0);
        cyc("pend_ovr", 1, 0, 1, 32'h300, 4'b1000, 0, 32'h300, 4'b1111, 4'b0000, 1, 1, 0);
        cyc("pend_rel", 1, 0, 0, 32'h0,   4'b0000, 1, 32'h200, 4'b0000, 4'b0011, 1, 0, 0);
        cyc("pend_fl",  1, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0011, 1, 0, 0);
        cyc("pend_run", 1, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);

        // Hold timeout: one pulse in the 4th hold cycle, re-armed by a release
        for (int k = 1; k <= 10; k++) begin
            cyc("tmo_a", 1, 0, 0, 32'h0, 4'b0001, 0, 0, 4'b0001, 4'b0010, 1, 0, (k == 4));
        end
        cyc("tmo_rel", 1, 0, 0, 32'h0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc("tmo_b", 1, 0, 0, 32'h0, 4'b0001, 0, 0, 4'b0001, 4'b0010, 1, 0, (k == 4));
        end
        cyc("tmo_rel2", 1, 0, 0, 32'h0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

        // Reset mid-PEND discards the parked jump
        cyc("rp_in",    1, 0, 1, 32'h240, 4'b1000, 0, 32'h240, 4'b1111, 4'b0000, 1, 0, 0);
        cyc("rp_rst",   1, 1, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);
        cyc("rp_post1", 1, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);
        cyc("rp_post2", 1, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);

        // Reset mid-FLUSH drops the remaining flush cycle
        cyc("rf_jmp",   1, 0, 1, 32'h260, 4'b0000, 1, 32'h260, 4'b0000, 4'b0011, 1, 0, 0);
        cyc("rf_rst",   1, 1, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);
        cyc("rf_post",  1, 0, 0, 32'h0,   4'b0000, 0, 0,       4'b0000, 4'b0000, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
